// File: rtl/dkong_pal_pkg.sv
// Shared types and helpers for the Donkey Kong palette lookup block.
package dkong_pal_pkg;

  // Loader state machine encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD0 = 2'd1,
    LOAD1 = 2'd2,
    DONE  = 2'd3
  } ld_state_t;

  // Loader image layouts
  localparam int LD_BYTE   = 0;  // one byte per palette entry
  localparam int LD_PLANES = 1;  // all low nibbles, then all high nibbles

  // Palette index width: bank field above the pixel code
  function automatic int calc_idx_w(input int bank_w, input int pix_w);
    return bank_w + pix_w;
  endfunction

  // Stored colour width: R, G and B packed MSB-first
  function automatic int calc_col_w(input int r_w, input int g_w, input int b_w);
    return r_w + g_w + b_w;
  endfunction

endpackage

// File: rtl/dkong_pal_lut_ram.sv
// Simple dual-port palette RAM: one nibble-enabled write port and one
// synchronous read port on a single clock. A read of the address being
// written in the same cycle returns the old contents.
module pal_ram_dp #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [1:0]    i_nbe,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  localparam int DEPTH = 1 << AW;
  localparam int LO_W  = (DW < 4) ? DW : 4;
  localparam int HI_W  = DW - LO_W;

  // The word is kept as two nibble arrays so each plane has its own enable
  logic [LO_W-1:0] r_mem_lo [DEPTH];
  logic [LO_W-1:0] r_rd_lo;

  // Low nibble plane: write on enable bit 0, read every clock
  always_ff @(posedge i_clk) begin
    if (i_we && i_nbe[0]) begin
      r_mem_lo[i_waddr] <= i_wdata[LO_W-1:0];
    end
    r_rd_lo <= r_mem_lo[i_raddr];
  end

  generate
    if (HI_W > 0) begin : g_hi
      logic [HI_W-1:0] r_mem_hi [DEPTH];
      logic [HI_W-1:0] r_rd_hi;

      // High nibble plane: write on enable bit 1, read every clock
      always_ff @(posedge i_clk) begin
        if (i_we && i_nbe[1]) begin
          r_mem_hi[i_waddr] <= i_wdata[DW-1:LO_W];
        end
        r_rd_hi <= r_mem_hi[i_raddr];
      end

      assign o_rdata = {r_rd_hi, r_rd_lo};
    end else begin : g_lo_only
      logic w_nbe_unused;
      assign w_nbe_unused = i_nbe[1];
      assign o_rdata      = r_rd_lo;
    end
  endgenerate

endmodule

// File: rtl/dkong_pal_lut.sv
// Video colour-palette lookup: picks object or background pixel code, forms
// a banked palette index, reads the palette RAM and drives blank-gated RGB.
// Also streams the palette image into RAM after reset via a loader FSM.
//
// Loader handshake: a byte is consumed on every rising clock edge where
// I_LD_VALID and O_LD_READY are both high; O_LD_READY depends only on the
// loader state, never on I_LD_VALID, and bytes offered while it is low are
// left untouched.
module dkong_pal_lut
  import dkong_pal_pkg::*;
#(
  parameter int PIX_W   = 6,
  parameter int BANK_W  = 2,
  parameter int R_W     = 3,
  parameter int G_W     = 3,
  parameter int B_W     = 2,
  parameter int LD_MODE = 1,
  parameter int INVERT  = 1
) (
  input  logic              CLK_12M,
  input  logic              I_RESETn,
  input  logic              I_PIX_CE,
  input  logic [PIX_W-1:0]  I_VRAM_D,
  input  logic [PIX_W-1:0]  I_OBJ_D,
  input  logic [BANK_W-1:0] I_BANK,
  input  logic              I_CMPBLKn,
  input  logic              I_LD_START,
  input  logic              I_LD_VALID,
  input  logic [7:0]        I_LD_DATA,
  output logic              O_LD_READY,
  output logic              O_LD_DONE,
  output logic              O_PAL_VALID,
  output logic [R_W-1:0]    O_R,
  output logic [G_W-1:0]    O_G,
  output logic [B_W-1:0]    O_B,
  output ld_state_t         O_DBG_STATE
);

  localparam int IDX_W = calc_idx_w(BANK_W, PIX_W);
  localparam int COL_W = calc_col_w(R_W, G_W, B_W);

  // Pixel pipeline registers
  logic [IDX_W-1:0] r_idx_q;
  logic             r_blk_q;
  logic [COL_W-1:0] r_col;

  // Loader registers
  ld_state_t        r_state;
  logic [IDX_W-1:0] r_cnt;
  logic             r_ld_ready;
  logic             r_ld_done;
  logic             r_pal_valid;

  // Combinational nets
  logic [PIX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_index;
  logic             w_hs;
  logic             w_cnt_last;
  logic [1:0]       w_nbe;
  logic [COL_W-1:0] w_wdata;
  logic [COL_W-1:0] w_rdata;
  logic [COL_W-1:0] w_rd_col;
  logic             w_ld_unused;

  // Object pixel wins unless its low two bits mark it transparent
  assign w_sel   = (I_OBJ_D[1:0] == 2'b00) ? I_VRAM_D : I_OBJ_D;
  assign w_index = {I_BANK, w_sel};

  assign w_hs       = I_LD_VALID & r_ld_ready;
  assign w_cnt_last = (r_cnt == {IDX_W{1'b1}});

  // Plane mode copies the low nibble of the byte into both halves; the
  // nibble enable decides which half actually lands in RAM.
  generate
    for (genvar g = 0; g < COL_W; g++) begin : g_wdata
      if (LD_MODE == LD_BYTE) begin : g_byte
        assign w_wdata[g] = I_LD_DATA[g];
      end else begin : g_plane
        assign w_wdata[g] = I_LD_DATA[g % 4];
      end
    end
  endgenerate

  // Bits of the loader byte that a given layout does not store
  assign w_ld_unused = ^I_LD_DATA;

  // Nibble enable: whole entry for byte layout, one plane per pass otherwise
  always_comb begin
    w_nbe = 2'b11;
    if (LD_MODE == LD_PLANES) begin
      w_nbe = (r_state == LOAD1) ? 2'b10 : 2'b01;
    end
  end

  pal_ram_dp #(
    .AW(IDX_W),
    .DW(COL_W)
  ) u_ram (
    .i_clk  (CLK_12M),
    .i_we   (w_hs),
    .i_nbe  (w_nbe),
    .i_waddr(r_cnt),
    .i_wdata(w_wdata),
    .i_raddr(r_idx_q),
    .o_rdata(w_rdata)
  );

  assign w_rd_col = (INVERT != 0) ? ~w_rdata : w_rdata;

  // Stage A: latch the palette index (forced to 0 while blanked) and blank
  always_ff @(posedge CLK_12M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_idx_q <= '0;
      r_blk_q <= 1'b1;
    end else if (I_PIX_CE) begin
      r_idx_q <= (!I_CMPBLKn) ? '0 : w_index;
      r_blk_q <= ~I_CMPBLKn;
    end
  end

  // Stage B: capture RAM data, black when blanked or palette not loaded
  always_ff @(posedge CLK_12M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_col <= '0;
    end else if (I_PIX_CE) begin
      r_col <= (r_blk_q || !r_pal_valid) ? '0 : w_rd_col;
    end
  end

  // Loader FSM: address counter, ready/done strobes and palette-valid flag
  always_ff @(posedge CLK_12M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ld_ready  <= 1'b0;
      r_ld_done   <= 1'b0;
      r_pal_valid <= 1'b0;
    end else begin
      r_ld_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (I_LD_START) begin
            r_state     <= LOAD0;
            r_cnt       <= '0;
            r_ld_ready  <= 1'b1;
            r_pal_valid <= 1'b0;
          end
        end
        LOAD0: begin
          if (w_hs) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_cnt_last) begin
              if (LD_MODE == LD_PLANES) begin
                r_state <= LOAD1;
              end else begin
                r_state     <= DONE;
                r_ld_ready  <= 1'b0;
                r_ld_done   <= 1'b1;
                r_pal_valid <= 1'b1;
              end
            end
          end
        end
        LOAD1: begin
          if (w_hs) begin
            r_cnt <= r_cnt + 1'b1;
            if (w_cnt_last) begin
              r_state     <= DONE;
              r_ld_ready  <= 1'b0;
              r_ld_done   <= 1'b1;
              r_pal_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state    <= IDLE;
          r_ld_ready <= 1'b0;
        end
      endcase
    end
  end

  assign O_LD_READY  = r_ld_ready;
  assign O_LD_DONE   = r_ld_done;
  assign O_PAL_VALID = r_pal_valid;
  assign O_R         = r_col[COL_W-1 -: R_W];
  assign O_G         = r_col[B_W +: G_W];
  assign O_B         = r_col[B_W-1:0];
  assign O_DBG_STATE = r_state;

endmodule
